// File: rtl/match_pkg.sv
// match_pkg: shared definitions for the consecutive-match tool chain.
//   - run FSM state encoding (S_IDLE / S_RUN and the matching enum)
//   - default widths for run-length entries and the completed-run total
package match_pkg;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  localparam int MATCH_CNT_W = 8;
  localparam int MATCH_TOT_W = 16;

  typedef enum logic {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN
  } run_state_e;

endpackage

// File: rtl/run_fifo.sv
// run_fifo: first-word-fall-through FIFO for completed run lengths.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (empties the FIFO)
//   push     in   write request; accepted when not full, or when full with a pop
//   din      in   DATA_W  entry to write
//   pop      in   read request; ignored while empty
//   dout     out  DATA_W  registered head entry (0 while empty)
//   empty    out  no entries stored
//   full     out  DEPTH entries stored
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module run_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [AW:0]       wr_ptr_d, rd_ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head_q, head_d;
  logic              pop_eff, push_eff, empty_d;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot the push lands in, so a full FIFO still accepts then.
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  assign wr_ptr_d = wr_ptr + (AW+1)'(push_eff);
  assign rd_ptr_d = rd_ptr + (AW+1)'(pop_eff);
  assign empty_d  = (wr_ptr_d == rd_ptr_d);

  // Head is registered: predict the entry at the next read index, taking the
  // word being written this edge when it lands exactly there.
  always_comb begin
    head_d = '0;
    if (!empty_d) begin
      if (push_eff && (rd_ptr_d[AW-1:0] == wr_ptr[AW-1:0])) begin
        head_d = din;
      end else begin
        head_d = mem[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      head_q <= head_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  assign dout = head_q;

endmodule

// File: rtl/match_run_logger.sv
// match_run_logger: measures every contiguous high run on match_in, queues
// the lengths for a valid/ready reader and keeps run statistics.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset; discards a run in progress
//   match_in   in   match level from the detector
//   run_len    out  CNT_W  head-of-FIFO run length (valid with run_valid)
//   run_valid  out  FIFO not empty
//   run_ready  in   reader accepts head entry when high with run_valid
//   busy       out  a run is in progress
//   run_count  out  TOT_W  completed runs since reset, dropped ones included
//   overflow   out  sticky: a completed run was dropped on a full FIFO
module match_run_logger
  import match_pkg::*;
#(
  parameter int CNT_W = MATCH_CNT_W,
  parameter int DEPTH = 4,
  parameter int TOT_W = MATCH_TOT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             match_in,
  output logic [CNT_W-1:0] run_len,
  output logic             run_valid,
  input  logic             run_ready,
  output logic             busy,
  output logic [TOT_W-1:0] run_count,
  output logic             overflow
);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q;
  logic [TOT_W-1:0] run_count_q;
  logic             overflow_q;
  logic             complete, pop, fifo_empty, fifo_full, drop;

  // Length increment that sticks at the all-ones maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (match_in)  state_d = ST_RUN;
      ST_RUN:  if (!match_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    complete = 1'b0;
    if (state_q == ST_RUN) begin
      busy     = 1'b1;
      complete = !match_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
    end else if (complete) begin
      len_q <= '0;
    end else if (match_in) begin
      len_q <= (state_q == ST_IDLE) ? CNT_W'(1) : sat_inc(len_q);
    end
  end

  assign run_valid = !fifo_empty;
  assign pop       = run_valid && run_ready;
  // A full FIFO only loses the entry when no pop frees a slot on this edge.
  assign drop      = complete && fifo_full && !pop;

  run_fifo #(
    .DATA_W (CNT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (complete),
    .din     (len_q),
    .pop     (pop),
    .dout    (run_len),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (complete) run_count_q <= run_count_q + TOT_W'(1);
      if (drop)     overflow_q  <= 1'b1;
    end
  end

  assign run_count = run_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_match_run_logger.sv
module tb_match_run_logger;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int TOT_W = 16;
  localparam int LEN_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             match_in;
  logic [CNT_W-1:0] run_len;
  logic             run_valid;
  logic             run_ready;
  logic             busy;
  logic [TOT_W-1:0] run_count;
  logic             overflow;

  int checks   = 0;
  int failures = 0;
  int busy_cycles;

  // Reference model / scoreboard state
  int unsigned sb[$];
  bit          m_busy;
  int          m_len;
  int          m_cnt;
  bit          m_ovf;

  always #5 clk = ~clk;

  match_run_logger #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH),
    .TOT_W (TOT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .match_in  (match_in),
    .run_len   (run_len),
    .run_valid (run_valid),
    .run_ready (run_ready),
    .busy      (busy),
    .run_count (run_count),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_busy = 1'b0;
    m_len  = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the reference behaviour with the inputs sampled there.
  task automatic model_step(input bit m, input bit r);
    bit pop_e, comp;
    pop_e = (sb.size() > 0) && r;
    comp  = m_busy && !m;
    if (pop_e) void'(sb.pop_front());
    if (comp) begin
      m_cnt = (m_cnt + 1) % (1 << TOT_W);
      if (sb.size() < DEPTH) sb.push_back(m_len);
      else m_ovf = 1'b1;
      m_len  = 0;
      m_busy = 1'b0;
    end else if (m) begin
      if (!m_busy) m_len = 1;
      else if (m_len < LEN_MAX) m_len++;
      m_busy = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("run_valid", 32'(run_valid), 32'(sb.size() > 0));
    if (sb.size() > 0) chk("run_len", 32'(run_len), sb[0]);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("run_count", 32'(run_count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input bit m, input bit r);
    match_in  = m;
    run_ready = r;
    @(posedge clk);
    model_step(m, r);
    #1;
    if (busy) busy_cycles++;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(run_valid), 0);
    chk({tag, "_len"}, 32'(run_len), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_count"}, 32'(run_count), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    match_in  = 1'b0;
    run_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
  endtask

  // Drain with ready high and count how many entries were present.
  task automatic drain(input string tag, input int exp_n);
    int n;
    n = 0;
    repeat (DEPTH + 2) begin
      if (run_valid) n++;
      cycle(1'b0, 1'b1);
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    reset_n   = 1'b0;
    match_in  = 1'b0;
    run_ready = 1'b0;

    // Single run of 5
    do_reset();
    busy_cycles = 0;
    repeat (5) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("t1_len", 32'(run_len), 5);
    chk("t1_count", 32'(run_count), 1);
    chk("t1_ovf", 32'(overflow), 0);
    chk("t1_busy_cycles", 32'(busy_cycles), 5);
    cycle(1'b0, 1'b1);
    chk("t1_popped", 32'(run_valid), 0);

    // Runs 1,3,2 held, then popped back to back
    cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("t2_head", 32'(run_len), 1);
    cycle(1'b0, 1'b1);
    chk("t2_second", 32'(run_len), 3);
    cycle(1'b0, 1'b1);
    chk("t2_third", 32'(run_len), 2);
    cycle(1'b0, 1'b1);
    chk("t2_empty", 32'(run_valid), 0);
    chk("t2_count", 32'(run_count), 4);

    // Overflow: five runs of 2 into a 4-deep FIFO
    do_reset();
    repeat (5) begin
      cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    end
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_count", 32'(run_count), 5);
    drain("t4_occupancy", 4);

    // Full FIFO, final run completes on a pop edge
    do_reset();
    repeat (4) begin
      cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_count", 32'(run_count), 5);
    drain("t5_occupancy", 4);

    // Saturation: long run clamps at 2^CNT_W-1
    do_reset();
    repeat (LEN_MAX + 45) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("t3_sat_len", 32'(run_len), LEN_MAX);
    chk("t3_count", 32'(run_count), 1);

    // Mid-run reset with two entries queued
    do_reset();
    cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
    chk("t6_queued", 32'(run_valid), 1);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_zero("t6_async");
    model_reset();
    #1 reset_n = 1'b1;
    repeat (4) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("t6_new_len", 32'(run_len), 4);
    chk("t6_new_count", 32'(run_count), 1);

    // Random traffic against the model
    repeat (400) cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
